memory_arbiter: RTL

//  Single-port RAM arbiter between the instruction fetch path and the request

---
 rtl/memory_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: serialises a latched data request and an
// instruction fetch onto one RAM port. Data requests win over fetches.
// Each access ends with a one-cycle ihit or dhit pulse and a one-cycle
// bubble in DONE, so two accesses are never issued back to back.
// A watchdog forces completion when the RAM does not answer in time.
// The watchdog fires in the access cycle whose wait count equals TIMEOUT.
// The count starts at 0, so an unanswered access spans TIMEOUT+1 cycles.
// The sticky timeout flag is set then and is cleared only by reset.
module memory_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hBAD1BAD1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_rdy,
    output logic              timeout
);

    localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    // The current access returns data. A write with dREN also set is not a read.
    logic             rd_reg;

    // Arbitration FSM; every output is a register, so the RAM port is
    // glitch-free and stays stable for the whole access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rd_reg    <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            iload     <= '0;
            dload     <= '0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
            timeout   <= 1'b0;
        end else begin
            // The hit strobes are single-cycle pulses unless set again below.
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (dREN || dWEN) begin
                        state_reg <= DACC;
                        ramaddr   <= daddr;
                        ramstore  <= dstore;
                        ramWEN    <= dWEN;
                        ramREN    <= dREN & ~dWEN;
                        rd_reg    <= ~dWEN;
                    end else if (iREN) begin
                        state_reg <= IACC;
                        ramaddr   <= iaddr;
                        ramWEN    <= 1'b0;
                        ramREN    <= 1'b1;
                        rd_reg    <= 1'b1;
                    end
                end
                DACC, IACC: begin
                    if (ram_rdy || (cnt_reg == CNT_MAX)) begin
                        state_reg <= DONE;
                        ramREN    <= 1'b0;
                        ramWEN    <= 1'b0;
                        if (state_reg == DACC) begin
                            dhit <= 1'b1;
                            if (rd_reg) begin
                                dload <= ram_rdy ? ramload : ERR_WORD;
                            end
                        end else begin
                            ihit <= 1'b1;
                            if (rd_reg) begin
                                iload <= ram_rdy ? ramload : ERR_WORD;
                            end
                        end
                        if (!ram_rdy) begin
                            timeout <= 1'b1;
                        end
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
